// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state type and a ceil-log2 helper.
// Also intended for the transmitter side.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK_WAIT
   } rx_state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible whenever not empty.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_pop;
   logic             do_push;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   // a pop in the same cycle frees the slot being written when full
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit majority voting, configurable framing and a FWFT output FIFO.
//
// state         | meaning
// RX_IDLE       | line idle, counters held at 0, waiting for a falling edge on rxs
// RX_START      | qualifying the start bit at mid-bit; a high vote is a false start
// RX_DATA       | shifting in DATA_BITS payload bits, LSB first
// RX_PARITY     | checking the parity bit against the received payload
// RX_STOP       | sampling stop bit(s); the word is pushed at the last stop decision
// RX_BREAK_WAIT | break received, waiting for the line to return high
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW > 0) ? DIV_RAW : 1;
   localparam int DIV_W   = (DIV > 1) ? clog2(DIV) : 1;
   localparam int OS_W    = clog2(OVERSAMPLE);
   localparam int BIT_W   = clog2(DATA_BITS);
   localparam int WORD_W  = DATA_BITS + 2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_LO    = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0]  OS_HI    = OS_W'(OVERSAMPLE / 2 + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LST = 1'(STOP_BITS - 1);
   localparam logic             PAR_EXP  = (PARITY == PAR_ODD);

   rx_state_t            state;
   logic                 rx_meta;
   logic                 rxs;
   logic                 rxs_prev;
   logic [DIV_W-1:0]     div_cnt;
   logic [OS_W-1:0]      os_cnt;
   logic [1:0]           votes;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 parity_err_int;
   logic                 frame_err_int;

   logic                 tick;
   logic                 decide;
   logic                 vote;
   logic                 frame_err_now;
   logic                 push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [WORD_W-1:0]    push_word;
   logic [WORD_W-1:0]    head_word;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= rx;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   assign tick          = (state != RX_IDLE) && (div_cnt == DIV_LAST);
   assign decide        = tick && (os_cnt == OS_HI);
   assign vote          = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);
   assign frame_err_now = frame_err_int | ~vote;
   assign push          = (state == RX_STOP) && decide && (stop_cnt == STOP_LST);
   assign push_word     = {frame_err_now, parity_err_int, shreg};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= RX_IDLE;
         div_cnt        <= '0;
         os_cnt         <= '0;
         votes          <= '0;
         bit_cnt        <= '0;
         stop_cnt       <= 1'b0;
         shreg          <= '0;
         parity_err_int <= 1'b0;
         frame_err_int  <= 1'b0;
      end else begin
         if (state == RX_IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
         end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (tick && (os_cnt == OS_LO))  votes[0] <= rxs;
         if (tick && (os_cnt == OS_MID)) votes[1] <= rxs;

         // state changes at the decision tick; os_cnt keeps running so the next bit lines up
         case (state)
            RX_IDLE: begin
               bit_cnt        <= '0;
               stop_cnt       <= 1'b0;
               parity_err_int <= 1'b0;
               frame_err_int  <= 1'b0;
               if (rxs_prev && !rxs) state <= RX_START;
            end
            RX_START: begin
               if (decide) state <= vote ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
               if (decide) begin
                  shreg   <= {vote, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST)
                     state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
               end
            end
            RX_PARITY: begin
               if (decide) begin
                  parity_err_int <= ((^shreg) ^ vote) != PAR_EXP;
                  state          <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (decide) begin
                  frame_err_int <= frame_err_now;
                  stop_cnt      <= stop_cnt + 1'b1;
                  if (stop_cnt == STOP_LST)
                     state <= (frame_err_now && (shreg == '0)) ? RX_BREAK_WAIT : RX_IDLE;
               end
            end
            RX_BREAK_WAIT: begin
               if (rxs) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) overrun <= 1'b0;
      else          overrun <= push && fifo_full && !(data_valid && data_ready);
   end

   uart_rx_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_word),
      .pop       (data_ready),
      .pop_data  (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign data_valid = !fifo_empty;
   assign data_out   = head_word[DATA_BITS-1:0];
   assign parity_err = head_word[DATA_BITS];
   assign frame_err  = head_word[DATA_BITS+1];
   assign busy       = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, 7E1 and 8N2 instances at 16x oversampling with a divide of 4.
module tb_uart_rx_os;

   localparam int CF  = 16 * 9600 * 4;
   localparam int BIT = 64;

   logic clk = 1'b0;
   logic reset_n;
   logic rx_a, rx_b, rx_c;
   logic ready_a, ready_b, ready_c;

   logic [7:0] do_a;
   logic [6:0] do_b;
   logic [7:0] do_c;
   logic dv_a, dv_b, dv_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;
   logic ovr_a, ovr_b, ovr_c, busy_a, busy_b, busy_c;

   int checks = 0;
   int errors = 0;
   int ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;
   logic [9:0] got_a[$];
   logic [8:0] got_b[$];
   logic [9:0] got_c[$];

   always #5 clk = ~clk;

   uart_rx_os #(.CLOCK_FREQ(CF), .BAUD_RATE(9600), .OVERSAMPLE(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .rx(rx_a), .data_out(do_a), .data_valid(dv_a),
      .data_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ovr_a), .busy(busy_a));

   uart_rx_os #(.CLOCK_FREQ(CF), .BAUD_RATE(9600), .OVERSAMPLE(16), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .rx(rx_b), .data_out(do_b), .data_valid(dv_b),
      .data_ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ovr_b), .busy(busy_b));

   uart_rx_os #(.CLOCK_FREQ(CF), .BAUD_RATE(9600), .OVERSAMPLE(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
      .clk(clk), .reset_n(reset_n), .rx(rx_c), .data_out(do_c), .data_valid(dv_c),
      .data_ready(ready_c), .parity_err(pe_c), .frame_err(fe_c), .overrun(ovr_c), .busy(busy_c));

   // record every accepted word and every overrun cycle
   always @(negedge clk) begin
      #1;
      if (reset_n) begin
         if (dv_a && ready_a) got_a.push_back({fe_a, pe_a, do_a});
         if (dv_b && ready_b) got_b.push_back({fe_b, pe_b, do_b});
         if (dv_c && ready_c) got_c.push_back({fe_c, pe_c, do_c});
         if (ovr_a) ovr_cnt_a++;
         if (ovr_b) ovr_cnt_b++;
         if (ovr_c) ovr_cnt_c++;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input int sel, input logic v);
      case (sel)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   // bits[0] goes out first; spike_bit gets a 1-clk inversion 32 clks into that bit
   task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int spike_bit);
      for (int i = 0; i < n; i++) begin
         set_rx(sel, bits[i]);
         if (i == spike_bit) begin
            repeat (32) @(negedge clk);
            set_rx(sel, ~bits[i]);
            @(negedge clk);
            set_rx(sel, bits[i]);
            repeat (BIT - 33) @(negedge clk);
         end else begin
            repeat (BIT) @(negedge clk);
         end
      end
      set_rx(sel, 1'b1);
   endtask

   function automatic logic [15:0] f8n1(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   initial begin
      reset_n = 1'b0;
      rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
      ready_a = 1'b0; ready_b = 1'b1; ready_c = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(dv_a), 32'd0);
      check("rst_data", 32'(do_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_overrun", 32'(ovr_a), 32'd0);
      check("rst_flags", 32'({fe_a, pe_a}), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // 8N1 back-to-back frames, consumer always ready
      ready_a = 1'b1;
      send_bits(0, f8n1(8'hA5), 10, -1);
      send_bits(0, f8n1(8'h3C), 10, -1);
      repeat (2 * BIT) @(negedge clk);
      check("t1_count", 32'(got_a.size()), 32'd2);
      check("t1_word0", 32'(got_a[0]), 32'({2'b00, 8'hA5}));
      check("t1_word1", 32'(got_a[1]), 32'({2'b00, 8'h3C}));
      check("t1_no_overrun", 32'(ovr_cnt_a), 32'd0);

      // 7E1: bad parity bit on 0x41, then correct parity on 0x43
      send_bits(1, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, -1);
      send_bits(1, {6'b0, 1'b1, 1'b1, 7'h43, 1'b0}, 10, -1);
      repeat (2 * BIT) @(negedge clk);
      check("t2_count", 32'(got_b.size()), 32'd2);
      check("t2_bad_parity", 32'(got_b[0]), 32'({1'b0, 1'b1, 7'h41}));
      check("t2_good_parity", 32'(got_b[1]), 32'({2'b00, 7'h43}));
      check("t2_busy", 32'(busy_b), 32'd0);

      // 8N2: second stop bit low on 0x55, then a clean 0x0F
      send_bits(2, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11, -1);
      repeat (BIT) @(negedge clk);
      send_bits(2, {5'b0, 1'b1, 1'b1, 8'h0F, 1'b0}, 11, -1);
      repeat (2 * BIT) @(negedge clk);
      check("t3_count", 32'(got_c.size()), 32'd2);
      check("t3_frame_err", 32'(got_c[0]), 32'({1'b1, 1'b0, 8'h55}));
      check("t3_clean", 32'(got_c[1]), 32'({2'b00, 8'h0F}));
      check("t3_overrun_bc", 32'(ovr_cnt_b + ovr_cnt_c), 32'd0);

      // short low glitch is a false start
      set_rx(0, 1'b0);
      repeat (10) @(negedge clk);
      check("t4_busy_on_edge", 32'(busy_a), 32'd1);
      repeat (9) @(negedge clk);
      set_rx(0, 1'b1);
      for (int i = 0; i < 45 && busy_a; i++) @(negedge clk);
      check("t4_false_start_idle", 32'(busy_a), 32'd0);
      repeat (BIT) @(negedge clk);
      check("t4_no_push", 32'(got_a.size()), 32'd2);
      send_bits(0, f8n1(8'hFF), 10, 4);
      repeat (2 * BIT) @(negedge clk);
      check("t4_spike_count", 32'(got_a.size()), 32'd3);
      check("t4_spike_word", 32'(got_a[2]), 32'({2'b00, 8'hFF}));

      // overrun: five frames into a four-entry FIFO with no consumer
      ready_a = 1'b0;
      for (int k = 1; k <= 5; k++) send_bits(0, f8n1(8'(k)), 10, -1);
      repeat (BIT) @(negedge clk);
      check("t5_overrun_once", 32'(ovr_cnt_a), 32'd1);
      check("t5_head_valid", 32'(dv_a), 32'd1);
      check("t5_head_data", 32'(do_a), 32'h01);
      ready_a = 1'b1;
      repeat (8) @(negedge clk);
      ready_a = 1'b0;
      check("t5_drain_count", 32'(got_a.size()), 32'd7);
      for (int k = 0; k < 4; k++) check("t5_drain_word", 32'(got_a[3 + k]), 32'(k + 1));
      check("t5_empty_valid", 32'(dv_a), 32'd0);
      check("t5_empty_data", 32'(do_a), 32'd0);

      // full FIFO: pop lands on the push edge of the fifth frame (last stop decision 619 clks in)
      for (int k = 0; k < 4; k++) send_bits(0, f8n1(8'h11 + 8'(k)), 10, -1);
      @(negedge clk);
      fork
         send_bits(0, f8n1(8'h15), 10, -1);
         begin
            repeat (618) @(negedge clk);
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check("t5_pushpop_no_overrun", 32'(ovr_cnt_a), 32'd1);
      check("t5_pushpop_popped", 32'(got_a[7]), 32'h11);
      ready_a = 1'b1;
      repeat (8) @(negedge clk);
      check("t5_pushpop_count", 32'(got_a.size()), 32'd12);
      for (int k = 0; k < 4; k++) check("t5_pushpop_word", 32'(got_a[8 + k]), 32'h12 + 32'(k));

      // break: line held low for three frame times
      set_rx(0, 1'b0);
      repeat (20 * BIT) @(negedge clk);
      check("t6_break_wait_busy", 32'(busy_a), 32'd1);
      check("t6_break_count", 32'(got_a.size()), 32'd13);
      check("t6_break_word", 32'(got_a[12]), 32'({1'b1, 1'b0, 8'h00}));
      repeat (10 * BIT) @(negedge clk);
      set_rx(0, 1'b1);
      repeat (2 * BIT) @(negedge clk);
      check("t6_single_break", 32'(got_a.size()), 32'd13);
      check("t6_idle", 32'(busy_a), 32'd0);

      // reset mid-frame flushes everything
      ready_a = 1'b0;
      send_bits(0, f8n1(8'h77), 10, -1);
      repeat (4) @(negedge clk);
      check("t6_pre_reset_valid", 32'(dv_a), 32'd1);
      send_bits(0, 16'b1010, 4, -1);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_rst_valid", 32'(dv_a), 32'd0);
      check("t6_rst_data", 32'(do_a), 32'd0);
      check("t6_rst_busy", 32'(busy_a), 32'd0);
      check("t6_rst_flags", 32'({ovr_a, fe_a, pe_a}), 32'd0);
      reset_n = 1'b1;
      repeat (12 * BIT) @(negedge clk);
      check("t6_post_reset_valid", 32'(dv_a), 32'd0);
      check("t6_post_reset_busy", 32'(busy_a), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
